rv32i_instr_encoder: RTL and testbench
======================================

# rv32i_instr_encoder

Streaming RV32I instruction encoder, the inverse of the team's RV32I decoder: accepts an operation code plus register and immediate operands and emits 32-bit machine words. It also expands the pseudo-instructions LI and CALL into two-word sequences. It sits between the boot/self-test sequence generator and the instruction memory write port, and emits words over a valid/ready stream.

## Interface
- Clocking: one clock; reset is asynchronous and active-low.
- No parameters. Operation codes and constants live in the shared package.
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  encoder accepts the request this cycle
- in_op  in  6  operation code; values from the package `enc_op_e`
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  signed immediate, byte offset, or full constant
- out_valid  out  1  emitted word valid
- out_ready  in  1  downstream accepts the word
- out_instr  out  32  encoded instruction word
- out_last  out  1  final word of the current request
- out_err  out  1  request was unencodable; `out_instr` is 32'h0000_0000
- words_emitted  out  16  count of completed output handshakes; wraps at 2^16

## Operation
- **Encoded operations.**
  - Base operations: all 37 RV32I base instructions.
  - System/fence: FENCE, FENCE_TSO, PAUSE, ECALL, EBREAK.
  - Pseudo-instructions: LI, CALL.
- **Immediate range rules.** A violation sets `out_err`; the request is then a single error word.
  - I-type and S-type: -2048..2047.
  - Shifts: 0..31, with funct7 0x20 for SRAI.
  - B-type: -4096..4094 and even.
  - J-type: -1048576..1048574 and even.
  - LUI/AUIPC: `in_imm` is the full constant; `imm[11:0]` must be 0.
- **System and fence words.**
  - FENCE: fm=0, pred=`imm[7:4]`, succ=`imm[3:0]`, rs1=rd=0.
  - Fixed words: FENCE_TSO 0x8330000F, PAUSE 0x0100000F, ECALL 0x00000073, EBREAK 0x00100073.
- **LI rd, imm.**
  - If imm fits 12-bit signed: a single `ADDI rd,x0,imm`.
  - Otherwise two words: `LUI rd,hi`, then `ADDI rd,rd,lo`.
  - lo = `imm[11:0]`; hi = `imm[31:12] + imm[11]`, modulo 2^20.
- **CALL imm.** Two words: `AUIPC x1,hi`, then `JALR x1,x1,lo`, with the same hi/lo split as LI. Never errors.
- **Unknown `in_op`.** A single error word.
- **State machine.**
  - States: IDLE (ready for a request) and SECOND (second word pending).
  - IDLE to SECOND: on accepting a two-word request. The first word is emitted with `out_last=0`.
  - SECOND to IDLE: when the second word is loaded into the output register (`out_last=1`).
- **Output register.**
  - Single stage: loads when `!out_valid || out_ready`.
  - `out_instr`, `out_last` and `out_err` are held stable while `out_valid && !out_ready`.
- **Input handshake.**
  - `in_ready = (state==IDLE) && (!out_valid || out_ready)`.
  - In SECOND, the request fields are held in an internal register; the input bus may change freely.
- **Reset values.**
  - Outputs: `out_valid=0`, `out_instr=0`, `out_last=0`, `out_err=0`, `words_emitted=0`.
  - State: IDLE.
  - Reset asserted mid-expansion discards the pending second word.

## Timing
- Latency: the word appears on `out_valid` the cycle after the input handshake.
- Throughput: 1 word/cycle with `out_ready` held high.
- Two-word requests occupy 2 cycles; `in_ready` is low for the cycle in SECOND.
- Simultaneous output handshake and new input handshake: the output register reloads with no bubble.
- `words_emitted` increments on the cycle of each `out_valid && out_ready`.
- No combinational path from `out_ready` to `out_valid`/`out_instr`.
- `in_ready` depends combinationally on `out_ready`.

## Structure
- Package `rv32_enc_pkg` holds:
  - the `enc_op_e` enum;
  - opcode constants (LUI 0x37, AUIPC 0x17, JAL 0x6F, JALR 0x67, BRANCH 0x63, LOAD 0x03, STORE 0x23, OP-IMM 0x13, OP 0x33, MISC-MEM 0x0F, SYSTEM 0x73);
  - funct3/funct7 constants;
  - fixed words for FENCE_TSO, PAUSE, ECALL, EBREAK.
- Sub-module `rv32i_enc_word`:
  - Combinational.
  - Inputs: op, rd, rs1, rs2, imm.
  - Outputs: word, err.
  - Does the field packing and range checks; instantiated once.
  - The top level selects first- or second-word operands per state.

## Test plan
- `ADDI x1,x0,5`, then `BEQ x1,x2,+8` back-to-back with `out_ready=1` → 0x00500093, then 0x00208463 on consecutive cycles, both `out_last=1`; `words_emitted=2`.
- `LI x5,0x12345678` → 0x123452B7 (`last=0`), then 0x67828293 (`last=1`).
- `LI x1,0x800` → 0x000010B7, then 0x80008093.
- `LI x1,-1` → single 0xFFF00093.
- `BEQ` with imm=7 → `out_err=1`, `out_instr=0`, `out_last=1`.
- `SLLI` with imm=32 → `out_err=1`, `out_instr=0`.
- `CALL` with `out_ready` low 3 cycles:
  - first word held stable and `in_ready=0` throughout;
  - ECALL presented during the stall is accepted only after the second CALL word;
  - ECALL emits 0x00000073.
- Assert `rst_n` while in SECOND → `out_valid=0` next edge, second word never emitted, `words_emitted=0`, `in_ready=1` after release.

Source files
------------

// File: rtl/rv32i_instr_encoder_pkg.sv
// Shared operation codes, RV32I opcode/funct constants and helpers for the
// streaming instruction encoder.
package rv32_enc_pkg;

  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_FENCE_TSO, OP_PAUSE, OP_ECALL, OP_EBREAK,
    OP_LI, OP_CALL
  } enc_op_e;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH, FMT_FENCE, FMT_FIXED, FMT_BAD
  } enc_fmt_e;

  typedef enum logic {ST_IDLE, ST_SECOND} enc_state_e;

  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [2:0] F3_B    = 3'd0;
  localparam logic [2:0] F3_H    = 3'd1;
  localparam logic [2:0] F3_W    = 3'd2;
  localparam logic [2:0] F3_BU   = 3'd4;
  localparam logic [2:0] F3_HU   = 3'd5;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] F3_JALR = 3'd0;
  localparam logic [2:0] F3_FENCE = 3'd0;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [31:0] WORD_FENCE_TSO = 32'h8330_000F;
  localparam logic [31:0] WORD_PAUSE     = 32'h0100_000F;
  localparam logic [31:0] WORD_ECALL     = 32'h0000_0073;
  localparam logic [31:0] WORD_EBREAK    = 32'h0010_0073;

  // True when v is representable as a 12-bit signed immediate.
  function automatic logic fits12(input logic [31:0] v);
    return (v[31:11] == '0) || (v[31:11] == '1);
  endfunction

endpackage

// File: rtl/rv32i_instr_encoder_if.sv
// Request and emitted-word stream between the sequence generator, the encoder
// and the instruction memory write port.
interface rv32i_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        out_err;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_last, out_err
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_last, out_err
  );
endinterface

// File: rtl/rv32i_instr_encoder_word.sv
// Combinational packer for one RV32I word: selects the format from the
// operation, range-checks the immediate and builds the machine word.
module rv32i_enc_word
  import rv32_enc_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);

  enc_fmt_e    fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] fixed_word;

  always_comb begin
    fmt        = FMT_BAD;
    opc        = '0;
    f3         = '0;
    f7         = F7_BASE;
    fixed_word = '0;
    case (op)
      OP_LUI:       begin fmt = FMT_U; opc = OPC_LUI;   end
      OP_AUIPC:     begin fmt = FMT_U; opc = OPC_AUIPC; end
      OP_JAL:       begin fmt = FMT_J; opc = OPC_JAL;   end
      OP_JALR:      begin fmt = FMT_I; opc = OPC_JALR; f3 = F3_JALR; end
      OP_BEQ:       begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ;  end
      OP_BNE:       begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE;  end
      OP_BLT:       begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLT;  end
      OP_BGE:       begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGE;  end
      OP_BLTU:      begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLTU; end
      OP_BGEU:      begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGEU; end
      OP_LB:        begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_B;  end
      OP_LH:        begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_H;  end
      OP_LW:        begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_W;  end
      OP_LBU:       begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_BU; end
      OP_LHU:       begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_HU; end
      OP_SB:        begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_B; end
      OP_SH:        begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_H; end
      OP_SW:        begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_W; end
      OP_ADDI:      begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_ADD;  end
      OP_SLTI:      begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SLT;  end
      OP_SLTIU:     begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SLTU; end
      OP_XORI:      begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_XOR;  end
      OP_ORI:       begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_OR;   end
      OP_ANDI:      begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_AND;  end
      OP_SLLI:      begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SLL; end
      OP_SRLI:      begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR;  end
      OP_SRAI:      begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR; f7 = F7_ALT; end
      OP_ADD:       begin fmt = FMT_R; opc = OPC_OP; f3 = F3_ADD;  end
      OP_SUB:       begin fmt = FMT_R; opc = OPC_OP; f3 = F3_ADD; f7 = F7_ALT; end
      OP_SLL:       begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SLL;  end
      OP_SLT:       begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SLT;  end
      OP_SLTU:      begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SLTU; end
      OP_XOR:       begin fmt = FMT_R; opc = OPC_OP; f3 = F3_XOR;  end
      OP_SRL:       begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SR;   end
      OP_SRA:       begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SR; f7 = F7_ALT; end
      OP_OR:        begin fmt = FMT_R; opc = OPC_OP; f3 = F3_OR;   end
      OP_AND:       begin fmt = FMT_R; opc = OPC_OP; f3 = F3_AND;  end
      OP_FENCE:     begin fmt = FMT_FENCE; opc = OPC_MISC_MEM; f3 = F3_FENCE; end
      OP_FENCE_TSO: begin fmt = FMT_FIXED; fixed_word = WORD_FENCE_TSO; end
      OP_PAUSE:     begin fmt = FMT_FIXED; fixed_word = WORD_PAUSE;     end
      OP_ECALL:     begin fmt = FMT_FIXED; fixed_word = WORD_ECALL;     end
      OP_EBREAK:    begin fmt = FMT_FIXED; fixed_word = WORD_EBREAK;    end
      default:      fmt = FMT_BAD;
    endcase
  end

  // Any range violation forces the all-zero error word.
  always_comb begin
    word = '0;
    err  = 1'b0;
    case (fmt)
      FMT_R: word = {f7, rs2, rs1, f3, rd, opc};
      FMT_I: begin
        err  = !fits12(imm);
        word = {imm[11:0], rs1, f3, rd, opc};
      end
      FMT_S: begin
        err  = !fits12(imm);
        word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      end
      FMT_B: begin
        err  = !((imm[31:12] == '0) || (imm[31:12] == '1)) || imm[0];
        word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      end
      FMT_U: begin
        err  = (imm[11:0] != '0);
        word = {imm[31:12], rd, opc};
      end
      FMT_J: begin
        err  = !((imm[31:20] == '0) || (imm[31:20] == '1)) || imm[0];
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      end
      FMT_SH: begin
        err  = (imm[31:5] != '0);
        word = {f7, imm[4:0], rs1, f3, rd, opc};
      end
      FMT_FENCE: word = {4'b0000, imm[7:4], imm[3:0], 5'd0, f3, 5'd0, opc};
      FMT_FIXED: word = fixed_word;
      default:   err = 1'b1;
    endcase
    if (err) begin
      word = '0;
    end
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Streaming RV32I encoder: one request in, one or two words out through a
// single-stage output register; LI and CALL expand to two words.
module rv32i_instr_encoder
  import rv32_enc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  rv32i_instr_encoder_if.slave  bus,
  output logic [15:0]           words_emitted
);

  enc_state_e  state_q, state_d;
  logic [5:0]  req_op_q, req_op_d;
  logic [4:0]  req_rd_q, req_rd_d;
  logic [31:0] req_imm_q, req_imm_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_last_q, out_last_d;
  logic        out_err_q, out_err_d;
  logic [15:0] words_q, words_d;

  logic        load;
  logic        accept;
  logic        two_word;
  logic [5:0]  src_op;
  logic [4:0]  src_rd;
  logic [31:0] src_imm;
  logic [31:0] hi_part;
  logic [31:0] lo_part;
  logic [5:0]  enc_op;
  logic [4:0]  enc_rd;
  logic [4:0]  enc_rs1;
  logic [4:0]  enc_rs2;
  logic [31:0] enc_imm;
  logic [31:0] enc_word;
  logic        enc_err;

  assign load     = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && bus.in_ready;
  assign two_word = ((bus.in_op == OP_LI) && !fits12(bus.in_imm)) || (bus.in_op == OP_CALL);

  assign bus.in_ready  = (state_q == ST_IDLE) && load;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_err   = out_err_q;
  assign words_emitted = words_q;

  // hi is rounded so that the sign-extended lo part added back gives imm.
  always_comb begin
    src_op  = (state_q == ST_SECOND) ? req_op_q  : bus.in_op;
    src_rd  = (state_q == ST_SECOND) ? req_rd_q  : bus.in_rd;
    src_imm = (state_q == ST_SECOND) ? req_imm_q : bus.in_imm;
    hi_part = (src_imm + 32'h0000_0800) & 32'hFFFF_F000;
    lo_part = src_imm - hi_part;
    enc_op  = src_op;
    enc_rd  = src_rd;
    enc_rs1 = bus.in_rs1;
    enc_rs2 = bus.in_rs2;
    enc_imm = src_imm;
    if (src_op == OP_LI) begin
      if (state_q == ST_SECOND) begin
        enc_op = OP_ADDI; enc_rs1 = src_rd; enc_imm = lo_part;
      end else if (fits12(src_imm)) begin
        enc_op = OP_ADDI; enc_rs1 = 5'd0;
      end else begin
        enc_op = OP_LUI; enc_imm = hi_part;
      end
    end else if (src_op == OP_CALL) begin
      enc_rd = 5'd1;
      if (state_q == ST_SECOND) begin
        enc_op = OP_JALR; enc_rs1 = 5'd1; enc_imm = lo_part;
      end else begin
        enc_op = OP_AUIPC; enc_imm = hi_part;
      end
    end
  end

  rv32i_enc_word u_word (
    .op   (enc_op),
    .rd   (enc_rd),
    .rs1  (enc_rs1),
    .rs2  (enc_rs2),
    .imm  (enc_imm),
    .word (enc_word),
    .err  (enc_err)
  );

  always_comb begin
    state_d     = state_q;
    req_op_d    = req_op_q;
    req_rd_d    = req_rd_q;
    req_imm_d   = req_imm_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    words_d     = words_q;
    if (out_valid_q && bus.out_ready) begin
      words_d = words_q + 16'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_instr_d = enc_word;
          out_last_d  = !two_word;
          out_err_d   = enc_err;
          if (two_word) begin
            state_d   = ST_SECOND;
            req_op_d  = bus.in_op;
            req_rd_d  = bus.in_rd;
            req_imm_d = bus.in_imm;
          end
        end else if (load) begin
          out_valid_d = 1'b0;
        end
      end
      ST_SECOND: begin
        if (load) begin
          out_valid_d = 1'b1;
          out_instr_d = enc_word;
          out_last_d  = 1'b1;
          out_err_d   = enc_err;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_op_q    <= '0;
      req_rd_q    <= '0;
      req_imm_q   <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_op_q    <= req_op_d;
      req_rd_q    <= req_rd_d;
      req_imm_q   <= req_imm_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
      words_q     <= words_d;
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Bench for rv32i_instr_encoder: directed literal cases plus randomized
// requests checked every cycle against a request-level reference model.
module tb_rv32i_instr_encoder;
  import rv32_enc_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        last;
    logic        err;
    int          cyc;
  } seen_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] words_emitted;

  rv32i_instr_encoder_if bus();

  rv32i_instr_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .words_emitted (words_emitted)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          check_en = 1'b0;
  exp_t        exp_q[$];
  seen_t       seen_q[$];
  logic [15:0] model_cnt = '0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_last;
  logic        prev_err;
  int          bnd [16] = '{0, -1, 2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096,
                            -4098, 31, 32, 1048574, 1048576, -1048576};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, 32'(act), 32'(exp));
  endtask

  // Reference encoder built from the instruction-format field layouts.
  function automatic logic [32:0] model_enc(input logic [5:0] op, input int rd, input int rs1,
                                            input int rs2, input int imm);
    int unsigned u, w, opc, f3, f7;
    byte fmt;
    bit ok;
    u = imm; w = 0; opc = 0; f3 = 0; f7 = 0; fmt = "?"; ok = 1'b1;
    case (op)
      OP_LUI:   begin fmt = "U"; opc = 'h37; end
      OP_AUIPC: begin fmt = "U"; opc = 'h17; end
      OP_JAL:   begin fmt = "J"; opc = 'h6F; end
      OP_JALR:  begin fmt = "I"; opc = 'h67; end
      OP_BEQ:   begin fmt = "B"; opc = 'h63; f3 = 0; end
      OP_BNE:   begin fmt = "B"; opc = 'h63; f3 = 1; end
      OP_BLT:   begin fmt = "B"; opc = 'h63; f3 = 4; end
      OP_BGE:   begin fmt = "B"; opc = 'h63; f3 = 5; end
      OP_BLTU:  begin fmt = "B"; opc = 'h63; f3 = 6; end
      OP_BGEU:  begin fmt = "B"; opc = 'h63; f3 = 7; end
      OP_LB:    begin fmt = "I"; opc = 'h03; f3 = 0; end
      OP_LH:    begin fmt = "I"; opc = 'h03; f3 = 1; end
      OP_LW:    begin fmt = "I"; opc = 'h03; f3 = 2; end
      OP_LBU:   begin fmt = "I"; opc = 'h03; f3 = 4; end
      OP_LHU:   begin fmt = "I"; opc = 'h03; f3 = 5; end
      OP_SB:    begin fmt = "S"; opc = 'h23; f3 = 0; end
      OP_SH:    begin fmt = "S"; opc = 'h23; f3 = 1; end
      OP_SW:    begin fmt = "S"; opc = 'h23; f3 = 2; end
      OP_ADDI:  begin fmt = "I"; opc = 'h13; f3 = 0; end
      OP_SLTI:  begin fmt = "I"; opc = 'h13; f3 = 2; end
      OP_SLTIU: begin fmt = "I"; opc = 'h13; f3 = 3; end
      OP_XORI:  begin fmt = "I"; opc = 'h13; f3 = 4; end
      OP_ORI:   begin fmt = "I"; opc = 'h13; f3 = 6; end
      OP_ANDI:  begin fmt = "I"; opc = 'h13; f3 = 7; end
      OP_SLLI:  begin fmt = "H"; f3 = 1; end
      OP_SRLI:  begin fmt = "H"; f3 = 5; end
      OP_SRAI:  begin fmt = "H"; f3 = 5; f7 = 'h20; end
      OP_ADD:   begin fmt = "R"; f3 = 0; end
      OP_SUB:   begin fmt = "R"; f3 = 0; f7 = 'h20; end
      OP_SLL:   begin fmt = "R"; f3 = 1; end
      OP_SLT:   begin fmt = "R"; f3 = 2; end
      OP_SLTU:  begin fmt = "R"; f3 = 3; end
      OP_XOR:   begin fmt = "R"; f3 = 4; end
      OP_SRL:   begin fmt = "R"; f3 = 5; end
      OP_SRA:   begin fmt = "R"; f3 = 5; f7 = 'h20; end
      OP_OR:    begin fmt = "R"; f3 = 6; end
      OP_AND:   begin fmt = "R"; f3 = 7; end
      OP_FENCE:     fmt = "F";
      OP_FENCE_TSO: begin fmt = "X"; w = 'h8330000F; end
      OP_PAUSE:     begin fmt = "X"; w = 'h0100000F; end
      OP_ECALL:     begin fmt = "X"; w = 'h00000073; end
      OP_EBREAK:    begin fmt = "X"; w = 'h00100073; end
      default:      fmt = "?";
    endcase
    case (fmt)
      "R": w = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h33;
      "I": begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = ((u % 4096) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + opc;
      end
      "S": begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = (((u >> 5) % 128) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + ((u % 32) << 7) + opc;
      end
      "B": begin
        ok = (imm >= -4096) && (imm <= 4094) && (u % 2 == 0);
        w  = (((u >> 12) % 2) << 31) + (((u >> 5) % 64) << 25) + (rs2 << 20) + (rs1 << 15) +
             (f3 << 12) + (((u >> 1) % 16) << 8) + (((u >> 11) % 2) << 7) + opc;
      end
      "U": begin
        ok = (u % 4096 == 0);
        w  = u - (u % 4096) + (rd << 7) + opc;
      end
      "J": begin
        ok = (imm >= -1048576) && (imm <= 1048574) && (u % 2 == 0);
        w  = (((u >> 20) % 2) << 31) + (((u >> 1) % 1024) << 21) + (((u >> 11) % 2) << 20) +
             (((u >> 12) % 256) << 12) + (rd << 7) + opc;
      end
      "H": begin
        ok = (imm >= 0) && (imm <= 31);
        w  = (f7 << 25) + ((u % 32) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
      end
      "F": w = (((u >> 4) % 16) << 24) + ((u % 16) << 20) + 'h0F;
      "X": ok = 1'b1;
      default: ok = 1'b0;
    endcase
    if (!ok) w = 0;
    return {!ok, w[31:0]};
  endfunction

  task automatic pushWord(input logic [32:0] r, input logic last);
    exp_t e;
    e.instr = r[31:0];
    e.err   = r[32];
    e.last  = last;
    exp_q.push_back(e);
  endtask

  // Expected words for one accepted request, in emission order.
  task automatic model_request(input logic [5:0] op, input int rd, input int rs1,
                               input int rs2, input int imm);
    int unsigned u, hi;
    int lo;
    u  = imm;
    hi = ((u >> 12) + ((u >> 11) % 2)) % (1 << 20);
    lo = int'(u % 4096);
    if (lo >= 2048) lo -= 4096;
    if (op == OP_LI) begin
      if (imm >= -2048 && imm <= 2047) begin
        pushWord(model_enc(OP_ADDI, rd, 0, 0, imm), 1'b1);
      end else begin
        pushWord(model_enc(OP_LUI, rd, 0, 0, int'(hi << 12)), 1'b0);
        pushWord(model_enc(OP_ADDI, rd, rd, 0, lo), 1'b1);
      end
    end else if (op == OP_CALL) begin
      pushWord(model_enc(OP_AUIPC, 1, 0, 0, int'(hi << 12)), 1'b0);
      pushWord(model_enc(OP_JALR, 1, 1, 0, lo), 1'b1);
    end else begin
      pushWord(model_enc(op, rd, rs1, rs2, imm), 1'b1);
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin : cmp_proc
    int   inflight;
    exp_t e;
    seen_t s;
    if (check_en) begin
      inflight = exp_q.size() - int'(bus.out_valid);
      checkBit("in_ready", bus.in_ready, (inflight == 0) && (!bus.out_valid || bus.out_ready));
      checkOutput("words_emitted", 32'(words_emitted), 32'(model_cnt));
      if (prev_stall) begin
        checkBit("hold_valid", bus.out_valid, 1'b1);
        checkOutput("hold_instr", bus.out_instr, prev_instr);
        checkBit("hold_last", bus.out_last, prev_last);
        checkBit("hold_err", bus.out_err, prev_err);
      end
      if (bus.out_valid && bus.out_ready) begin
        model_cnt = model_cnt + 16'd1;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_word", bus.out_instr, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_instr", bus.out_instr, e.instr);
          checkBit("out_last", bus.out_last, e.last);
          checkBit("out_err", bus.out_err, e.err);
        end
        s.instr = bus.out_instr; s.last = bus.out_last; s.err = bus.out_err; s.cyc = cyc;
        seen_q.push_back(s);
      end
      if (bus.in_valid && bus.in_ready) begin
        model_request(bus.in_op, int'(bus.in_rd), int'(bus.in_rs1), int'(bus.in_rs2), int'(bus.in_imm));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_instr = bus.out_instr;
      prev_last  = bus.out_last;
      prev_err   = bus.out_err;
    end
  end

  task automatic resetDut();
    check_en     = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    seen_q.delete();
    model_cnt  = '0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_en = 1'b1;
  endtask

  // Presents a request and holds it until accepted, bounded in cycles.
  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm);
    bit got;
    got = 1'b0;
    bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checkBit("accept", got, 1'b1);
  endtask

  task automatic drain(input int n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkSeen(input string name, input int idx, input logic [31:0] instr,
                           input logic last, input logic err);
    checkBit({name, "_present"}, seen_q.size() > idx, 1'b1);
    if (seen_q.size() > idx) begin
      checkOutput({name, "_instr"}, seen_q[idx].instr, instr);
      checkBit({name, "_last"}, seen_q[idx].last, last);
      checkBit({name, "_err"}, seen_q[idx].err, err);
    end
  endtask

  initial begin
    int op, kind, imm;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    #12;
    checkBit("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_out_instr", bus.out_instr, 32'h0);
    checkBit("rst_out_last", bus.out_last, 1'b0);
    checkBit("rst_out_err", bus.out_err, 1'b0);
    checkOutput("rst_words", 32'(words_emitted), 32'h0);
    resetDut();

    applyStimulus(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    applyStimulus(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd8);
    drain(3);
    checkSeen("addi", 0, 32'h0050_0093, 1'b1, 1'b0);
    checkSeen("beq", 1, 32'h0020_8463, 1'b1, 1'b0);
    if (seen_q.size() >= 2) checkOutput("b2b_gap", 32'(seen_q[1].cyc - seen_q[0].cyc), 32'd1);
    checkOutput("b2b_words", 32'(words_emitted), 32'd2);

    seen_q.delete();
    applyStimulus(OP_LI, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    applyStimulus(OP_LI, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    applyStimulus(OP_LI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    applyStimulus(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd7);
    applyStimulus(OP_SLLI, 5'd3, 5'd4, 5'd0, 32'd32);
    drain(4);
    checkSeen("li_big_hi", 0, 32'h1234_52B7, 1'b0, 1'b0);
    checkSeen("li_big_lo", 1, 32'h6782_8293, 1'b1, 1'b0);
    checkSeen("li_800_hi", 2, 32'h0000_10B7, 1'b0, 1'b0);
    checkSeen("li_800_lo", 3, 32'h8000_8093, 1'b1, 1'b0);
    checkSeen("li_m1", 4, 32'hFFF0_0093, 1'b1, 1'b0);
    checkSeen("beq_odd", 5, 32'h0, 1'b1, 1'b1);
    checkSeen("slli_32", 6, 32'h0, 1'b1, 1'b1);

    seen_q.delete();
    bus.out_ready = 1'b0;
    applyStimulus(OP_CALL, 5'd0, 5'd0, 5'd0, 32'h0000_1000);
    bus.in_op = OP_ECALL; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkBit("stall_in_ready", bus.in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    applyStimulus(OP_ECALL, 5'd0, 5'd0, 5'd0, 32'h0);
    drain(4);
    checkSeen("call_auipc", 0, 32'h0000_1097, 1'b0, 1'b0);
    checkSeen("call_jalr", 1, 32'h0000_80E7, 1'b1, 1'b0);
    checkSeen("ecall", 2, 32'h0000_0073, 1'b1, 1'b0);

    resetDut();
    applyStimulus(OP_LI, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    check_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checkBit("midrst_out_valid", bus.out_valid, 1'b0);
    checkOutput("midrst_words", 32'(words_emitted), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete(); seen_q.delete(); model_cnt = '0; prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkBit("midrst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    check_en = 1'b1;
    drain(4);
    checkOutput("midrst_no_second", 32'(seen_q.size()), 32'd0);
    checkOutput("midrst_words_after", 32'(words_emitted), 32'h0);

    for (int n = 0; n < 1500; n++) begin
      op = $urandom_range(0, 47);
      kind = $urandom_range(0, 3);
      case (kind)
        0:       imm = int'($urandom_range(0, 40)) - 20;
        1:       imm = bnd[$urandom_range(0, 15)];
        2:       imm = int'($urandom);
        default: imm = int'($urandom & 32'hFFFF_F000);
      endcase
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_op  = 6'(op);
      bus.in_rd  = 5'($urandom);
      bus.in_rs1 = 5'($urandom);
      bus.in_rs2 = 5'($urandom);
      bus.in_imm = imm;
      @(posedge clk);
      #1;
    end
    drain(10);
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
